// File: rtl/chip_prog_receiver.sv
// chip_prog_receiver: chip-side serial gain programming receiver.
// Ports: i_mainclk/i_reset, i_sclk/i_sdin (async serial in), o_gainA1, o_ready, o_busy, o_frame_err.
module chip_prog_receiver #(
  parameter int                 NBITS        = 5,
  parameter int                 HDRBITS      = 2,
  parameter logic [HDRBITS-1:0] HEADER       = 2'b00,
  parameter int                 TIMEOUT      = 64,
  parameter int                 DEFAULT_GAIN = 0
) (
  input  logic                       i_mainclk,
  input  logic                       i_reset,
  input  logic                       i_sclk,
  input  logic                       i_sdin,
  output logic [NBITS-HDRBITS-1:0]   o_gainA1,
  output logic                       o_ready,
  output logic                       o_busy,
  output logic                       o_frame_err
);

  localparam int GW = NBITS - HDRBITS;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = $clog2(NBITS + 1);

  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]       r_state;
  logic             r_sclk_s1;
  logic             r_sclk_s2;
  logic             r_sclk_s3;
  logic             r_sdin_s1;
  logic             r_sdin_s2;
  logic [NBITS-2:0] r_shift;
  logic [BW-1:0]    r_bitcnt;
  logic [TW-1:0]    r_tmo;
  logic [GW-1:0]    r_gain;
  logic             r_ready;
  logic             r_busy;
  logic             r_err;

  logic               w_rise;
  logic               w_fall;
  logic               w_last;
  logic [NBITS-1:0]   w_word;
  logic [HDRBITS-1:0] w_hdr;

  assign w_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_last = (r_bitcnt == LAST_BIT);
  // Completed word includes the bit arriving this cycle.
  assign w_word = {r_shift, r_sdin_s2};
  assign w_hdr  = w_word[NBITS-1 -: HDRBITS];

  // Synchronizers reset to the sclk idle level so reset never fakes an edge.
  always_ff @(posedge i_mainclk) begin
    if (i_reset) begin
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_s3 <= 1'b1;
      r_sdin_s1 <= 1'b1;
      r_sdin_s2 <= 1'b1;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_sdin_s1 <= i_sdin;
      r_sdin_s2 <= r_sdin_s1;
    end
  end

  always_ff @(posedge i_mainclk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_tmo    <= '0;
      r_gain   <= GW'(DEFAULT_GAIN);
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state  <= S_RECV;
            r_bitcnt <= '0;
            r_tmo    <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_RECV: begin
          if (w_rise) begin
            r_shift  <= w_word[NBITS-2:0];
            r_bitcnt <= r_bitcnt + 1'b1;
            r_tmo    <= '0;
            if (w_last) begin
              r_busy <= 1'b0;
              if (w_hdr == HEADER) begin
                r_state <= S_DONE;
                r_gain  <= w_word[GW-1:0];
                r_ready <= 1'b1;
                r_err   <= 1'b0;
              end else begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end
            end
          end else if (r_tmo == TMO_MAX) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE: begin
          // Reprogram: gain keeps its old value until the new frame lands.
          if (w_fall) begin
            r_state  <= S_RECV;
            r_ready  <= 1'b0;
            r_bitcnt <= '0;
            r_tmo    <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_ERR: begin
          if (w_fall) begin
            r_state  <= S_RECV;
            r_err    <= 1'b0;
            r_bitcnt <= '0;
            r_tmo    <= '0;
            r_busy   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gainA1    = r_gain;
  assign o_ready     = r_ready;
  assign o_busy      = r_busy;
  assign o_frame_err = r_err;

endmodule
